// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned CLKFREQ    = 28000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int unsigned INH_CYC   = CLKFREQ * INHIBIT_US / 1000;
  localparam int unsigned START_CYC = CLKFREQ / 1000;
  localparam int unsigned TO_CYC    = CLKFREQ * TIMEOUT_MS;
  localparam int unsigned MAX_CYC   = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
  localparam int unsigned FILT_N    = 8;
  localparam int unsigned FILT_W    = $clog2(FILT_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_RELEASE
  } state_t;

  logic [1:0]        r_clk_sync;
  logic [1:0]        r_dat_sync;
  logic              r_filt;
  logic [FILT_W-1:0] r_fcnt;
  logic              r_fall;
  logic              w_dat;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tmr, w_tmr_nxt;
  logic [3:0]        r_bitcnt, w_bitcnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_parity, w_parity_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic              r_clk_oe, w_clk_oe_nxt;
  logic              r_dat_oe, w_dat_oe_nxt;
  logic              w_timeout;

  // Pad synchronizers and an 8-sample glitch filter on the device clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_fcnt     <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2data_in};
      r_fall     <= 1'b0;
      if (r_clk_sync[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FILT_W'(FILT_N - 1)) begin
        r_fcnt <= '0;
        r_filt <= r_clk_sync[1];
        r_fall <= r_filt;
      end else begin
        r_fcnt <= r_fcnt + FILT_W'(1);
      end
    end
  end

  assign w_dat = r_dat_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tmr    <= w_tmr_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = r_tmr;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_timeout    = (r_tmr == CNT_W'(TO_CYC - 1));

    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        if (send) begin
          w_shift_nxt  = data_in;
          w_parity_nxt = ~^data_in;
          w_state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_tmr == CNT_W'(INH_CYC - 1)) begin
          w_tmr_nxt    = '0;
          w_dat_oe_nxt = 1'b1;
          w_state_nxt  = S_START;
        end else begin
          w_tmr_nxt = r_tmr + CNT_W'(1);
        end
      end
      S_START: begin
        if (r_tmr == CNT_W'(START_CYC - 1)) begin
          w_tmr_nxt    = '0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_BITS;
        end else begin
          w_tmr_nxt = r_tmr + CNT_W'(1);
        end
      end
      S_BITS: begin
        if (r_fall) begin
          w_tmr_nxt    = '0;
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt < 4'd8) begin
            w_dat_oe_nxt = ~r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[7:1]};
          end else if (r_bitcnt == 4'd8) begin
            w_dat_oe_nxt = ~r_parity;
          end else begin
            w_dat_oe_nxt = 1'b0;
            w_state_nxt  = S_ACK;
          end
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (r_fall) begin
          w_tmr_nxt = '0;
          if (!w_dat) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_filt && w_dat) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_fall) begin
          w_tmr_nxt = '0;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Host only owns the clock line while inhibiting and during request-to-send
    w_clk_oe_nxt = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_START);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_IDLE) begin
      w_dat_oe_nxt = 1'b0;
      w_tmr_nxt    = '0;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector pad model plus a behavioural PS/2 device.
module tb_ps2_host_tx;

  localparam int CLKFREQ    = 4000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_MS = 2;
  localparam int INH_CYC    = CLKFREQ * INHIBIT_US / 1000;
  localparam int START_CYC  = CLKFREQ / 1000;
  localparam int TO_CYC     = CLKFREQ * TIMEOUT_MS;
  localparam int HALF       = 40;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       send;
  logic       busy, done, error, ps2clk_oe, ps2data_oe;
  logic       dev_clk, dev_data;
  logic       ps2clk_in, ps2data_in;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  exp_t exp_q[$];

  assign ps2clk_in  = dev_clk & ~ps2clk_oe;
  assign ps2data_in = dev_data & ~ps2data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLKFREQ   (CLKFREQ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .send      (send),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  // Every completion pulse must be exclusive and coincide with busy low
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done || error) begin
      total++;
      if ((done && error) || busy !== 1'b0) begin
        bad++;
        $display("FAIL pulse_excl: done=%b error=%b busy=%b, want one pulse with busy 0", done, error, busy);
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(d[i]);
    return (c % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic ok, output logic bz);
    exp_t e;
    @(negedge clk);
    data_in = d;
    send    = 1'b1;
    e.data = d;
    e.par  = odd_par(d);
    e.ack  = ok;
    exp_q.push_back(e);
    @(negedge clk);
    send    = 1'b0;
    data_in = ~d;
    bz      = busy;
  endtask

  task automatic host_request(output int inh_n, output int st_n, output logic sb, output logic held);
    inh_n = 0;
    st_n  = 0;
    held  = 1'b1;
    while (ps2data_oe !== 1'b1 && inh_n < 4 * INH_CYC) begin
      if (ps2clk_oe !== 1'b1) held = 1'b0;
      @(negedge clk);
      inh_n++;
    end
    while (ps2clk_oe !== 1'b0 && st_n < 100) begin
      @(negedge clk);
      st_n++;
    end
    sb = ps2data_in;
  endtask

  task automatic dev_clock(input int nfalls, input logic ack_low, input bit glitch, output logic [9:0] bits);
    bits = '1;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nfalls; k++) begin
      if (k == 10) dev_data = ack_low ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k < 10) bits[k] = ps2data_in;
      if (k == nfalls - 1 && nfalls < 11) return;
      dev_clk = 1'b1;
      if (glitch && k == 3) begin
        repeat (20) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 23) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic settle(input int d0, input int e0, output int dn, output int en);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    dn = done_cnt - d0;
    en = err_cnt - e0;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, error, ps2clk_oe, ps2data_oe} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 00000", {busy, done, error, ps2clk_oe, ps2data_oe});
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || ps2clk_oe !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: activity=%b want 0", seen);
    end
  endtask

  task automatic test_basic();
    logic [9:0] bits;
    logic       bz, sb, held;
    int         inh_n, st_n, d0, e0, dn, en;
    exp_t       e;
    send_byte(8'hED, 1'b1, bz);
    d0 = done_cnt;
    e0 = err_cnt;
    host_request(inh_n, st_n, sb, held);
    dev_clock(11, 1'b1, 1'b0, bits);
    settle(d0, e0, dn, en);
    e = exp_q.pop_front();
    total++;
    if (bz !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bz); end
    total++;
    if (inh_n != INH_CYC || held !== 1'b1) begin
      bad++;
      $display("FAIL basic_inhibit: len=%0d held=%b want %0d,1", inh_n, held, INH_CYC);
    end
    total++;
    if (st_n != START_CYC || sb !== 1'b0) begin
      bad++;
      $display("FAIL basic_start: len=%0d bit=%b want %0d,0", st_n, sb, START_CYC);
    end
    total++;
    if (bits[7:0] !== e.data || bits[7:0] !== 8'hED) begin
      bad++;
      $display("FAIL basic_data: got %h want %h", bits[7:0], e.data);
    end
    total++;
    if (bits[8] !== e.par || bits[8] !== 1'b1) begin
      bad++;
      $display("FAIL basic_parity: got %b want %b", bits[8], e.par);
    end
    total++;
    if (bits[9] !== 1'b1) begin bad++; $display("FAIL basic_stop: got %b want 1", bits[9]); end
    total++;
    if (dn != 1 || en != 0) begin
      bad++;
      $display("FAIL basic_outcome: done=%0d error=%0d want 1,0", dn, en);
    end
  endtask

  task automatic test_parity();
    logic [9:0] bits;
    logic       bz, sb, held;
    int         inh_n, st_n, d0, e0, dn, en;
    exp_t       e;
    logic [7:0] pats[2];
    logic       want_par[2];
    pats[0] = 8'h00; want_par[0] = 1'b1;
    pats[1] = 8'h01; want_par[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_byte(pats[i], 1'b1, bz);
      d0 = done_cnt;
      e0 = err_cnt;
      host_request(inh_n, st_n, sb, held);
      dev_clock(11, 1'b1, 1'b0, bits);
      settle(d0, e0, dn, en);
      e = exp_q.pop_front();
      total++;
      if (bits[7:0] !== e.data) begin
        bad++;
        $display("FAIL parity_data%0d: got %h want %h", i, bits[7:0], e.data);
      end
      total++;
      if (bits[8] !== want_par[i] || bits[8] !== e.par) begin
        bad++;
        $display("FAIL parity_bit%0d: got %b want %b", i, bits[8], want_par[i]);
      end
      total++;
      if (dn != 1 || en != 0) begin
        bad++;
        $display("FAIL parity_outcome%0d: done=%0d error=%0d want 1,0", i, dn, en);
      end
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    logic       bz, sb, held;
    int         inh_n, st_n, d0, e0, dn, en;
    exp_t       e;
    send_byte(8'h3C, 1'b0, bz);
    d0 = done_cnt;
    e0 = err_cnt;
    host_request(inh_n, st_n, sb, held);
    dev_clock(11, 1'b0, 1'b0, bits);
    settle(d0, e0, dn, en);
    e = exp_q.pop_front();
    total++;
    if (bits[8:0] !== {e.par, e.data}) begin
      bad++;
      $display("FAIL nack_frame: got %h want %h", bits[8:0], {e.par, e.data});
    end
    total++;
    if (dn != int'(e.ack) || en != 1) begin
      bad++;
      $display("FAIL nack_outcome: done=%0d error=%0d want 0,1", dn, en);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL nack_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic bz, sb, held;
    int   inh_n, st_n, n, d0;
    exp_t e;
    send_byte(8'h5A, 1'b0, bz);
    d0 = done_cnt;
    host_request(inh_n, st_n, sb, held);
    n = 0;
    while (error !== 1'b1 && n < TO_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    total++;
    if (n != TO_CYC) begin bad++; $display("FAIL timeout_len: got %0d want %0d", n, TO_CYC); end
    total++;
    if ({ps2clk_oe, ps2data_oe, busy} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_release: oe/busy=%b want 000", {ps2clk_oe, ps2data_oe, busy});
    end
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt - d0 != int'(e.ack)) begin
      bad++;
      $display("FAIL timeout_nodone: done=%0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    logic       bz, sb, held;
    int         inh_n, st_n, d0, e0, dn, en;
    exp_t       e;
    send_byte(8'hA5, 1'b1, bz);
    host_request(inh_n, st_n, sb, held);
    dev_clock(4, 1'b1, 1'b0, bits);
    total++;
    if (ps2data_oe !== 1'b1) begin
      bad++;
      $display("FAIL midrst_bit3: data_oe=%b want 1", ps2data_oe);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ps2clk_oe, ps2data_oe, busy} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_immediate: oe/busy=%b want 000", {ps2clk_oe, ps2data_oe, busy});
    end
    exp_q.delete();
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt != d0 || err_cnt != e0) begin
      bad++;
      $display("FAIL midrst_nopulse: done=%0d error=%0d want 0,0", done_cnt - d0, err_cnt - e0);
    end
    send_byte(8'hF4, 1'b1, bz);
    d0 = done_cnt;
    e0 = err_cnt;
    host_request(inh_n, st_n, sb, held);
    dev_clock(11, 1'b1, 1'b0, bits);
    settle(d0, e0, dn, en);
    e = exp_q.pop_front();
    total++;
    if (bits !== {1'b1, e.par, e.data}) begin
      bad++;
      $display("FAIL midrst_f4_frame: got %h want %h", bits, {1'b1, e.par, e.data});
    end
    total++;
    if (dn != 1 || en != 0) begin
      bad++;
      $display("FAIL midrst_f4_outcome: done=%0d error=%0d want 1,0", dn, en);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    logic       bz, sb, held, seen;
    int         inh_n, st_n, d0, e0, dn, en;
    exp_t       e;
    send_byte(8'hFF, 1'b1, bz);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      begin
        host_request(inh_n, st_n, sb, held);
        dev_clock(11, 1'b1, 1'b1, bits);
      end
      begin
        repeat (600) @(negedge clk);
        data_in = 8'hAA;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
      end
    join
    settle(d0, e0, dn, en);
    e = exp_q.pop_front();
    total++;
    if (bits !== {1'b1, e.par, e.data}) begin
      bad++;
      $display("FAIL b2b_frame: got %h want %h", bits, {1'b1, e.par, e.data});
    end
    total++;
    if (dn != 1 || en != 0) begin
      bad++;
      $display("FAIL b2b_outcome: done=%0d error=%0d want 1,0", dn, en);
    end
    seen = 1'b0;
    repeat (3 * INH_CYC) begin
      @(negedge clk);
      if (busy !== 1'b0 || ps2clk_oe !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL b2b_no_second: activity=%b want 0", seen); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_queue: left=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n    = 1'b0;
    send     = 1'b0;
    data_in  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLKFREQ, default 28000; system clock frequency in kHz.
REQ-002 Parameter INHIBIT_US, default 100; clock-inhibit time before a request-to-send, in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15; maximum wait for any device clock edge, in milliseconds.
REQ-004 clk  input  1  system clock (sysclk, 28 MHz); all logic rises on it.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  command byte to send to the PS/2 device (e.g. keyboard LED or mouse command).
REQ-007 send  input  1  one-cycle start strobe; sampled only in IDLE.
REQ-008 busy  output  1  high from the cycle after an accepted send until return to IDLE.
REQ-009 done  output  1  one-cycle pulse; transfer completed with device ACK.
REQ-010 error  output  1  one-cycle pulse; transfer aborted (timeout or missing ACK).
REQ-011 ps2clk_in  input  1  raw level of the bidirectional PS/2 clock pad (asynchronous).
REQ-012 ps2data_in  input  1  raw level of the bidirectional PS/2 data pad (asynchronous).
REQ-013 ps2clk_oe  output  1  1 = top level drives the clock pad low; 0 = pad is high-Z.
REQ-014 ps2data_oe  output  1  1 = top level drives the data pad low; 0 = pad is high-Z.

Function
REQ-015 ps2clk_in and ps2data_in SHALL each pass through a 2-flop synchronizer; the synchronized clock SHALL then be filtered, so that its level changes only after 8 consecutive identical samples.
REQ-016 A device clock falling edge (fall) SHALL be a filtered clock transition from 1 to 0, flagged for one cycle.
REQ-017 States SHALL be IDLE, INHIBIT, START, BITS, ACK, RELEASE.
REQ-018 IDLE: both OEs 0, busy 0; on send=1, latch data_in, compute odd parity (parity = ~^data_in) and go to INHIBIT.
REQ-019 INHIBIT: ps2clk_oe=1 for CLKFREQ*INHIBIT_US/1000 cycles (2800 at defaults), then START.
REQ-020 START: ps2clk_oe=1 and ps2data_oe=1 (start bit 0) for CLKFREQ/1000 cycles (28); then ps2clk_oe=0, clear the bit counter, go to BITS.
REQ-021 BITS: on each fall, advance the bit counter and present the next frame bit: falls 1-8 give D0..D7 (LSB first), fall 9 gives parity, fall 10 gives stop (ps2data_oe=0); go to ACK after fall 10.
REQ-022 Frame bit value b SHALL be driven as ps2data_oe = ~b.
REQ-023 ACK: on the next fall, sample the synchronized data; 0 gives RELEASE, 1 gives an error pulse and IDLE.
REQ-024 RELEASE: wait until the filtered clock and the synchronized data are both 1, then pulse done and go to IDLE.
REQ-025 Timeout counter SHALL clear on entry to BITS and on every fall; if it reaches CLKFREQ*TIMEOUT_MS (420000) in BITS, ACK or RELEASE, release both OEs, pulse error and go to IDLE.
REQ-026 send while busy SHALL be ignored; data_in is not re-sampled during a transfer.
REQ-027 done and error SHALL never be asserted in the same cycle; busy deasserts in the cycle done or error pulses.
REQ-028 ps2clk_oe SHALL never be 1 in BITS, ACK or RELEASE (device owns the clock).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0, counters 0, and synchronizers/filter to 1; a transfer in progress is abandoned without any pulse.

Verification
REQ-030 send with 0xED, device model clocks at 12 kHz and ACKs -> clk_oe low for 2800 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulse once, error 0.
REQ-031 send with 0x00 -> parity bit 1; send with 0x01 -> parity bit 0; both end in done.
REQ-032 device never clocks after START -> error pulse exactly 420000 cycles after BITS entry, both OEs 0.
REQ-033 device holds data high at the ACK edge -> error pulse, no done, return to IDLE.
REQ-034 rst_n low during bit 4 -> both OEs 0 in the same cycle, busy 0; a later send with 0xF4 completes normally.
REQ-035 second send during a busy transfer of 0xFF, plus 3-cycle glitches on the clock -> only 0xFF transmitted, glitches produce no fall.
